// File: rtl/pal_timing_gen.sv
// Purpose : PAL raster timing - hc/vc counters, composite sync with equalising/broad
//           pulses, optional 625-line interlace, active-window video blanking.
// Latency : csync and video_out are registered, 1 cycle behind hc/vc; frame_start is combinational.
// Backpress: none; free-running from the pixel clock.
//
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   interlace    mode request, taken at field end only
//   video_in     pixel for the current hc/vc
//   hc, vc       raster counters
//   field        current field (0 in progressive mode)
//   frame_start  high while hc==0 && vc==0
//   csync        composite sync, active low
//   video_out    video_in gated by the active window
module pal_timing_gen #(
  parameter int CW         = 9,
  parameter int HTOTAL     = 448,
  parameter int VTOTAL     = 312,
  parameter int HSYNC_LEN  = 33,
  parameter int EQ_LEN     = 16,
  parameter int HACT_START = 96,
  parameter int HACT_END   = 416,
  parameter int VACT_START = 24,
  parameter int VACT_END   = 304
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          interlace,
  input  logic          video_in,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          field,
  output logic          frame_start,
  output logic          csync,
  output logic          video_out
);

  localparam int HALF = HTOTAL / 2;
  // Slot arithmetic is two bits wider than the counters so that slot -1
  // (first half of line 0 in field 1) wraps to a large value, not into 0..17.
  localparam int SW   = CW + 2;

  localparam logic [CW-1:0] H_LAST   = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] H_HALF   = CW'(HALF);
  localparam logic [CW-1:0] V_LAST0  = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] V_LAST1  = CW'(VTOTAL);
  localparam logic [CW-1:0] HS_LEN   = CW'(HSYNC_LEN);
  localparam logic [CW-1:0] EQ_W     = CW'(EQ_LEN);
  localparam logic [CW-1:0] BROAD_W  = CW'(HALF - HSYNC_LEN);
  localparam logic [CW-1:0] HA_START = CW'(HACT_START);
  localparam logic [CW-1:0] HA_END   = CW'(HACT_END);
  localparam logic [CW-1:0] VA_START = CW'(VACT_START);
  localparam logic [CW-1:0] VA_END   = CW'(VACT_END);
  localparam logic [SW-1:0] S_PRE    = SW'(6);
  localparam logic [SW-1:0] S_BROAD  = SW'(12);
  localparam logic [SW-1:0] S_POST   = SW'(18);

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          field_q, field_d;
  logic          csync_q, csync_d;
  logic          video_q, video_d;

  logic [CW-1:0] v_last;
  logic          hc_wrap;
  logic          field_end;
  logic          second_half;
  logic [SW-1:0] half_idx;
  logic [SW-1:0] slot;
  logic [CW-1:0] pos;
  logic          sync_low;
  logic          active;

  always_comb begin
    // Field 1 carries the extra line of the 625-line frame.
    v_last    = field_q ? V_LAST1 : V_LAST0;
    hc_wrap   = (hc_q == H_LAST);
    field_end = hc_wrap && (vc_q == v_last);

    hc_d = hc_wrap ? '0 : hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_wrap) begin
      vc_d = field_end ? '0 : vc_q + 1'b1;
    end

    // Mode is only ever taken at the field boundary.
    field_d = field_q;
    if (field_end) begin
      field_d = interlace ? ~field_q : 1'b0;
    end

    second_half = (hc_q >= H_HALF);
    half_idx    = {1'b0, vc_q, second_half};
    slot        = half_idx - SW'(field_q);
    pos         = second_half ? (hc_q - H_HALF) : hc_q;

    if (slot < S_PRE) begin
      sync_low = (pos < EQ_W);
    end else if (slot < S_BROAD) begin
      sync_low = (pos < BROAD_W);
    end else if (slot < S_POST) begin
      sync_low = (pos < EQ_W);
    end else begin
      // Normal line: one hsync at the line start, nothing in the second half.
      sync_low = !second_half && (hc_q < HS_LEN);
    end

    active = (hc_q >= HA_START) && (hc_q < HA_END) &&
             (vc_q >= VA_START) && (vc_q < VA_END);

    csync_d = ~sync_low;
    video_d = video_in & active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q    <= '0;
      vc_q    <= '0;
      field_q <= 1'b0;
      csync_q <= 1'b1;
      video_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      field_q <= field_d;
      csync_q <= csync_d;
      video_q <= video_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign field       = field_q;
  assign frame_start = (hc_q == '0) && (vc_q == '0);
  assign csync       = csync_q;
  assign video_out   = video_q;

endmodule

// File: tb/tb_pal_timing_gen.sv
// Purpose : directed check of pal_timing_gen on a scaled raster (60x24 lines).
// Latency : expects csync/video_out one cycle behind hc/vc.
// Backpress: none.
module tb_pal_timing_gen;

  localparam int CW  = 6;
  localparam int HT  = 60;
  localparam int VT  = 24;
  localparam int HS  = 5;
  localparam int EQ  = 3;
  localparam int HAS = 10;
  localparam int HAE = 50;
  localparam int VAS = 12;
  localparam int VAE = 20;
  localparam int FIELD0_CYC = VT * HT;
  localparam int FIELD1_CYC = (VT + 1) * HT;
  localparam int ACT_CNT    = (HAE - HAS) * (VAE - VAS);
  localparam int BOUND      = 4000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          interlace;
  logic          video_in;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          field;
  logic          frame_start;
  logic          csync;
  logic          video_out;

  pal_timing_gen #(
    .CW(CW), .HTOTAL(HT), .VTOTAL(VT), .HSYNC_LEN(HS), .EQ_LEN(EQ),
    .HACT_START(HAS), .HACT_END(HAE), .VACT_START(VAS), .VACT_END(VAE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .interlace(interlace), .video_in(video_in),
    .hc(hc), .vc(vc), .field(field), .frame_start(frame_start),
    .csync(csync), .video_out(video_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: csync/video_out belong to the hc/vc seen one sample earlier.
  logic [HT-1:0] cs_map [2][VT+1];
  int   prev_hc, prev_vc, prev_field;
  bit   prev_valid = 0;
  int   vid_acc = 0, vid_last = 0;
  bit   seen_vid = 0;
  int   first_hc = -1, first_vc = -1;
  int   field1_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      if (prev_valid) begin
        cs_map[prev_field][prev_vc][prev_hc] = csync;
        if (video_out) begin
          vid_acc++;
          if (!seen_vid) begin
            seen_vid = 1;
            first_hc = prev_hc;
            first_vc = prev_vc;
          end
        end
      end
      if (frame_start) begin
        vid_last = vid_acc;
        vid_acc  = 0;
        seen_vid = 0;
      end
      if (field) field1_seen++;
      prev_hc    = int'(hc);
      prev_vc    = int'(vc);
      prev_field = int'(field);
      prev_valid = 1;
    end
  end

  task automatic wait_fs(output int t);
    int n = 0;
    @(negedge clk);
    while (!frame_start && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_timeout", 64'(n >= BOUND), 64'd0);
    #1;
    t = cyc;
  endtask

  task automatic wait_pos(input int v, input int h);
    int n = 0;
    @(negedge clk);
    while (!(int'(vc) == v && int'(hc) == h) && n < 2 * BOUND) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos_timeout", 64'(n >= 2 * BOUND), 64'd0);
  endtask

  typedef struct {
    int f;
    int v;
    int s0;
    int l0;
    int s1;
    int l1;
  } line_vec_t;

  line_vec_t tbl [18];

  task automatic check_lines(input int f);
    foreach (tbl[i]) begin
      logic [HT-1:0] e;
      if (tbl[i].f == f) begin
        e = '1;
        for (int h = 0; h < HT; h++) begin
          if (h >= tbl[i].s0 && h < tbl[i].s0 + tbl[i].l0) e[h] = 1'b0;
          if (h >= tbl[i].s1 && h < tbl[i].s1 + tbl[i].l1) e[h] = 1'b0;
        end
        check($sformatf("csync_f%0d_vc%0d", f, tbl[i].v), 64'(cs_map[f][tbl[i].v]), 64'(e));
      end
    end
  endtask

  int t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;

  initial begin
    // Expected low runs per line: {field, vc, start0, len0, start1, len1}.
    tbl[0]  = '{0,  0, 0,  3, 30,  3};
    tbl[1]  = '{0,  2, 0,  3, 30,  3};
    tbl[2]  = '{0,  3, 0, 25, 30, 25};
    tbl[3]  = '{0,  5, 0, 25, 30, 25};
    tbl[4]  = '{0,  6, 0,  3, 30,  3};
    tbl[5]  = '{0,  8, 0,  3, 30,  3};
    tbl[6]  = '{0,  9, 0,  5,  0,  0};
    tbl[7]  = '{0, 15, 0,  5,  0,  0};
    tbl[8]  = '{0, 23, 0,  5,  0,  0};
    tbl[9]  = '{1,  0, 0,  5, 30,  3};
    tbl[10] = '{1,  1, 0,  3, 30,  3};
    tbl[11] = '{1,  3, 0,  3, 30, 25};
    tbl[12] = '{1,  4, 0, 25, 30, 25};
    tbl[13] = '{1,  6, 0, 25, 30,  3};
    tbl[14] = '{1,  8, 0,  3, 30,  3};
    tbl[15] = '{1,  9, 0,  3,  0,  0};
    tbl[16] = '{1, 10, 0,  5,  0,  0};
    tbl[17] = '{1, 24, 0,  5,  0,  0};

    rst_n = 1'b0;
    interlace = 1'b0;
    video_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hc", 64'(hc), 64'd0);
    check("rst_vc", 64'(vc), 64'd0);
    check("rst_field", 64'(field), 64'd0);
    check("rst_csync", 64'(csync), 64'd1);
    check("rst_video", 64'(video_out), 64'd0);

    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("frame_start_after_release", 64'(frame_start), 64'd1);
    @(posedge clk);
    #1 check("hc_first_edge", 64'(hc), 64'd1);

    // Reset mid-line: outputs return at once, without a clock edge.
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", {hc, vc, csync, video_out, field}, {6'd0, 6'd0, 1'b1, 1'b0, 1'b0});
    repeat (5) @(negedge clk);
    check("midrst_held", {hc, vc, csync, video_out, field}, {6'd0, 6'd0, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Progressive fields.
    wait_fs(t0);
    wait_fs(t1);
    check("prog_period", 64'(t1 - t0), 64'(FIELD0_CYC));
    check_lines(0);
    check("prog_video_count", 64'(vid_last), 64'(ACT_CNT));
    check("video_first_pos", {32'(first_vc), 32'(first_hc)}, {32'(VAS), 32'(HAS)});

    // Interlace requested mid-field 0: takes effect at its end.
    interlace = 1'b1;
    wait_fs(t2);
    check("il_period0", 64'(t2 - t1), 64'(FIELD0_CYC));
    check("il_field1", 64'(field), 64'd1);
    wait_fs(t3);
    check("il_period1", 64'(t3 - t2), 64'(FIELD1_CYC));
    check("il_field0", 64'(field), 64'd0);
    wait_fs(t4);
    check("il_period2", 64'(t4 - t3), 64'(FIELD0_CYC));
    wait_fs(t5);
    check("il_period3", 64'(t5 - t4), 64'(FIELD1_CYC));
    check("il_video_count_f1", 64'(vid_last), 64'(ACT_CNT));
    check_lines(1);
    wait_fs(t6);
    check("il_period4", 64'(t6 - t5), 64'(FIELD0_CYC));
    check("il_field1_again", 64'(field), 64'd1);

    // Drop interlace halfway through field 1: it still runs 25 lines.
    wait_pos(12, 0);
    interlace = 1'b0;
    wait_fs(t7);
    check("switch_f1_len", 64'(t7 - t6), 64'(FIELD1_CYC));
    check("switch_field0", 64'(field), 64'd0);
    field1_seen = 0;
    wait_fs(t8);
    check("switch_prog_len_a", 64'(t8 - t7), 64'(FIELD0_CYC));
    wait_fs(t9);
    check("switch_prog_len_b", 64'(t9 - t8), 64'(FIELD0_CYC));
    check("switch_field_stays0", 64'(field1_seen), 64'd0);

    // video_in gating inside the active window.
    wait_pos(15, 20);
    video_in = 1'b0;
    @(negedge clk);
    check("video_gated_off", 64'(video_out), 64'd0);
    video_in = 1'b1;
    @(negedge clk);
    check("video_pass_on", 64'(video_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pal_timing_gen.md
# pal_timing_gen

Parametrised successor to the fixed 448×312 PAL timing/sync path. It owns the horizontal and vertical counters (hc/vc) consumed by the frame generator, produces composite sync with true equalising and broad pulses, and blanks the incoming video outside a programmable active window. A run-time `interlace` mode selects 625-line interlaced operation (alternating 312/313-line fields with half-line sync offset) or 312-line progressive operation.

## Interface
- `CW`, 9: hc/vc counter width; must satisfy `2^CW > VTOTAL`.
- `HTOTAL`, 448: clocks per line (64 µs at 7 MHz); must be even; `HALF = HTOTAL/2`.
- `VTOTAL`, 312: lines in a progressive field and in interlaced field 0.
- `HSYNC_LEN`, 33: line-sync low width, clocks.
- `EQ_LEN`, 16: equalising-pulse low width, clocks.
- `HACT_START`, 96 / `HACT_END`, 416: active hc window `[START, END)`.
- `VACT_START`, 24 / `VACT_END`, 304: active vc window `[START, END)`.

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `interlace` in 1: mode request; sampled only at field end.
- `video_in` in 1: pixel from the frame generator for the current hc/vc.
- `hc` out CW: horizontal counter.
- `vc` out CW: vertical counter.
- `field` out 1: current field; always 0 in progressive mode.
- `frame_start` out 1: one-cycle strobe while `hc==0 && vc==0`.
- `csync` out 1: composite sync, active low, registered.
- `video_out` out 1: blanked video, registered.

## Operation
- `hc` counts 0..HTOTAL-1 and wraps. `vc` advances on the hc wrap and runs 0..LAST, with `LAST = VTOTAL-1`, or `VTOTAL` when `field==1`.
- Field end is `hc==HTOTAL-1 && vc==LAST`. In that cycle `interlace` is sampled:
  - If 1: `field` toggles.
  - If 0: `field` goes to 0.
  - A mode change therefore never takes effect mid-field.
- Half-line index is `h = 2*vc + (hc>=HALF)`. Sync slot is `s = h - field`. Position within the half-line is `p = hc mod HALF`.
- Half-line class:
  - `0<=s<6`: pre-equalising. csync low when `p < EQ_LEN`.
  - `6<=s<12`: broad. csync low when `p < HALF-HSYNC_LEN`.
  - `12<=s<18`: post-equalising. csync low when `p < EQ_LEN`.
  - Otherwise normal: csync low when `hc < HSYNC_LEN`; high for the whole second half-line.
- In field 1, `s = -1` (the first half of line 0) is therefore a normal hsync. The sync sequence starts at hc=HALF, which gives the 312.5-line field spacing.
- Active window is `HACT_START<=hc<HACT_END && VACT_START<=vc<VACT_END`. `video_out = video_in & active`.
- All comparisons are unsigned. `s` is computed CW+2 bits wide so that `s = -1` does not alias into the sync range.

## Timing
- Reset values (asynchronous, while `rst_n==0`): `hc=0`, `vc=0`, `field=0`, `csync=1`, `video_out=0`.
- `frame_start` is combinational from the counters, so it is 1 in the first cycle after reset release.
- `csync` and `video_out` are registered. Both reflect the hc/vc values of the previous cycle (latency 1), so they stay mutually aligned.
- The first clock edge after reset release advances `hc` to 1.
- Field length:
  - Progressive: `VTOTAL*HTOTAL` clocks.
  - Interlaced: alternately `VTOTAL*HTOTAL` and `(VTOTAL+1)*HTOTAL` clocks.
- Reset asserted mid-field aborts the field immediately: all outputs return to their reset values and no partial pulse is held.
- A simultaneous field end and `interlace` edge is resolved by the value of `interlace` in the field-end cycle.

## Test plan
- Reset: hold `rst_n=0` 5 cycles mid-line, then release. Required: `hc=vc=0`, `csync=1`, `video_out=0` during reset; `frame_start=1` in the first cycle after release.
- Progressive line sync: `interlace=0`, observe vc=100. Required: csync low exactly 33 cycles, appearing 1 cycle after hc=0; high for the rest of the line.
- Progressive vertical sync: check lines 0..8. Required:
  - vc 0..2: 6 pulses of 16 low, spaced 224.
  - vc 3..5: 6 broad pulses of 191 low.
  - vc 6..8: 6 pulses of 16 low.
  - `frame_start` period 139776 cycles.
- Interlace: `interlace=1` for 4 fields. Required:
  - `frame_start` intervals alternate 139776 and 140224.
  - Field 1: vc=0 shows a 33-cycle hsync at hc=0, then the first 16-cycle equalising pulse at hc=224.
- Mode switch: drop `interlace` midway through field 1. Required: field 1 completes with 313 lines, then `field=0` permanently.
- Blanking: `video_in=1` constantly. Required: `video_out` high exactly 320×280 = 89600 cycles per field, first high 1 cycle after hc=96, vc=24.
